// File: rtl/roi_pkg.sv
// Shared types and constants for the ROI window overlay controller.
package roi_pkg;

  localparam int XW = 11;
  localparam int YW = 10;

  localparam logic [XW-1:0] X1_RST = 11'd10;
  localparam logic [XW-1:0] X2_RST = 11'd110;
  localparam logic [YW-1:0] Y1_RST = 10'd10;
  localparam logic [YW-1:0] Y2_RST = 10'd80;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef struct packed {
    logic [XW-1:0] x1;
    logic [XW-1:0] x2;
    logic [YW-1:0] y1;
    logic [YW-1:0] y2;
  } bounds_t;

  localparam bounds_t BOUNDS_RST = {X1_RST, X2_RST, Y1_RST, Y2_RST};

  function automatic logic bounds_legal(input bounds_t b);
    return (b.x1 <= b.x2) && (b.y1 <= b.y2);
  endfunction

  // Inclusive on all four edges; no wrap-around.
  function automatic logic in_window(input bounds_t b, input logic [XW-1:0] x,
                                     input logic [YW-1:0] y);
    return (x >= b.x1) && (x <= b.x2) && (y >= b.y1) && (y <= b.y2);
  endfunction

endpackage

// File: rtl/roi_window_ctrl_if.sv
// Bounds-update request bus from the two requesters (0 = UI, 1 = tracker).
interface roi_window_ctrl_if;
  import roi_pkg::*;

  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [2*XW-1:0] req_x1;
  logic [2*XW-1:0] req_x2;
  logic [2*YW-1:0] req_y1;
  logic [2*YW-1:0] req_y2;

  modport master (output req_valid, req_x1, req_x2, req_y1, req_y2, input req_ready);
  modport slave  (input req_valid, req_x1, req_x2, req_y1, req_y2, output req_ready);

endinterface

// File: rtl/roi_rr_arb2.sv
// Two-way round-robin arbiter; a tie goes to the requester not granted last.
module roi_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       gate,
  output logic [1:0] gnt
);

  logic last_gnt_reg;

  always_comb begin
    gnt = 2'b00;
    if (gate) begin
      if (valid == 2'b11) gnt = last_gnt_reg ? 2'b01 : 2'b10;
      else                gnt = valid;
    end
  end

  // Any grant is a completed handshake because ready is the grant itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     last_gnt_reg <= 1'b1;
    else if (|gnt) last_gnt_reg <= gnt[1];
  end

endmodule

// File: rtl/roi_window_ctrl.sv
// ROI window controller: arbitrates bound updates, commits them at frame start,
// and produces the registered overlay flag for the pixel pipeline.
module roi_window_ctrl
  import roi_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [XW-1:0]    gr_x,
  input  logic [YW-1:0]    gr_y,
  roi_window_ctrl_if.slave req,
  output logic             pending,
  output logic             err,
  output logic             commit,
  output logic             outg
);

  state_t  state_reg, state_next;
  bounds_t active_reg, shadow_reg;
  bounds_t req_arr [2];
  bounds_t req_b, eff_b;
  logic [1:0] gnt;
  logic fs, accept, legal, hold_fs;
  logic err_reg, commit_reg, outg_reg;

  assign fs = en && (gr_x == '0) && (gr_y == '0);

  roi_rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .valid (req.req_valid),
    .gate  (state_reg == IDLE),
    .gnt   (gnt)
  );

  assign req.req_ready = gnt;

  for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
    assign req_arr[gi] = {req.req_x1[gi*XW +: XW], req.req_x2[gi*XW +: XW],
                          req.req_y1[gi*YW +: YW], req.req_y2[gi*YW +: YW]};
  end

  assign req_b   = req_arr[gnt[1]];
  assign accept  = |(req.req_valid & gnt);
  assign legal   = bounds_legal(req_b);
  assign hold_fs = (state_reg == HOLD) && fs;

  // The commit pixel itself is already drawn with the incoming bounds.
  assign eff_b = hold_fs ? shadow_reg : active_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept && legal) state_next = HOLD;
      HOLD:    if (fs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      active_reg <= BOUNDS_RST;
      shadow_reg <= BOUNDS_RST;
      err_reg    <= 1'b0;
      commit_reg <= 1'b0;
      outg_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      err_reg    <= accept && !legal;
      commit_reg <= hold_fs;
      outg_reg   <= en && in_window(eff_b, gr_x, gr_y);
      if (accept && legal) shadow_reg <= req_b;
      if (hold_fs)         active_reg <= shadow_reg;
    end
  end

  assign pending = (state_reg == HOLD);
  assign err     = err_reg;
  assign commit  = commit_reg;
  assign outg    = outg_reg;

endmodule

// File: tb/tb_roi_window_ctrl.sv
// Self-checking bench for roi_window_ctrl: directed scenarios plus randomized traffic.
module tb_roi_window_ctrl;
  import roi_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [XW-1:0] gr_x;
  logic [YW-1:0] gr_y;
  logic          pending, err, commit, outg;

  roi_window_ctrl_if ifc ();

  roi_window_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .gr_x    (gr_x),
    .gr_y    (gr_y),
    .req     (ifc),
    .pending (pending),
    .err     (err),
    .commit  (commit),
    .outg    (outg)
  );

  always #5 clk = ~clk;

  typedef struct { int x1; int x2; int y1; int y2; } box_t;

  // Reference model: window rectangles as plain integers.
  box_t m_act, m_shd;
  bit   m_hold;
  int   m_last;
  box_t rq [2];

  logic [1:0] obs_ready, exp_ready;
  logic [3:0] exp_vec;
  int checks = 0;
  int failures = 0;

  function automatic box_t rand_box(input bit legal);
    box_t b;
    int a, c;
    a = $urandom_range(0, 2047); c = $urandom_range(0, 2047);
    b.x1 = (a < c) ? a : c; b.x2 = (a < c) ? c : a;
    a = $urandom_range(0, 1023); c = $urandom_range(0, 1023);
    b.y1 = (a < c) ? a : c; b.y2 = (a < c) ? c : a;
    if ($urandom_range(0, 3) == 0) b.x2 = 2047;
    if (!legal) begin
      if ($urandom_range(0, 1) == 1) begin
        b.x1 = $urandom_range(1, 2047); b.x2 = $urandom_range(0, b.x1 - 1);
      end else begin
        b.y1 = $urandom_range(1, 1023); b.y2 = $urandom_range(0, b.y1 - 1);
      end
    end
    return b;
  endfunction

  task automatic set_req(input int n, input box_t b);
    rq[n] = b;
    ifc.req_x1[n*XW +: XW] = XW'(b.x1);
    ifc.req_x2[n*XW +: XW] = XW'(b.x2);
    ifc.req_y1[n*YW +: YW] = YW'(b.y1);
    ifc.req_y2[n*YW +: YW] = YW'(b.y2);
  endtask

  task automatic pix(input int x, input int y, input bit e);
    en = e; gr_x = XW'(x); gr_y = YW'(y);
  endtask

  // Advances one clock; samples ready mid-cycle and predicts the registered outputs.
  task automatic tick();
    bit fs, hit;
    int who, gx, gy;
    box_t eff, r;
    @(negedge clk);
    obs_ready = ifc.req_ready;
    gx = int'(gr_x); gy = int'(gr_y);
    fs = (en === 1'b1) && gx == 0 && gy == 0;
    exp_ready = 2'b00;
    who = -1;
    if (!m_hold && ifc.req_valid != 2'b00) begin
      if (ifc.req_valid == 2'b11) who = 1 - m_last;
      else who = ifc.req_valid[1] ? 1 : 0;
      exp_ready = (who == 1) ? 2'b10 : 2'b01;
    end
    eff = (m_hold && fs) ? m_shd : m_act;
    hit = (en === 1'b1) && gx >= eff.x1 && gx <= eff.x2 && gy >= eff.y1 && gy <= eff.y2;
    exp_vec = {hit, 1'b0, m_hold && fs, 1'b0};
    if (m_hold) begin
      if (fs) begin m_act = m_shd; m_hold = 0; end
    end else if (who >= 0) begin
      r = rq[who];
      m_last = who;
      $display("grant req%0d bounds {%0d,%0d,%0d,%0d}", who, r.x1, r.x2, r.y1, r.y2);
      if (r.x1 <= r.x2 && r.y1 <= r.y2) begin m_shd = r; m_hold = 1; end
      else exp_vec[2] = 1'b1;
    end
    exp_vec[0] = m_hold;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    en = 0; gr_x = '0; gr_y = '0; ifc.req_valid = 2'b00;
    reset = 1'b0; #1;
    reset = 1'b1; #2;
    checks++;
    if ({outg, err, commit, pending, ifc.req_ready} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs got %b want 000000", {outg, err, commit, pending, ifc.req_ready});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    m_act = '{10, 110, 10, 80}; m_shd = m_act; m_hold = 0; m_last = 1;
  endtask

  task automatic test_default_window();
    int rows [6] = '{0, 9, 10, 45, 80, 81};
    ifc.req_valid = 2'b00;
    foreach (rows[r]) begin
      for (int x = 0; x <= 120; x++) begin
        pix(x, rows[r], 1); tick();
        checks++;
        if ({outg, err, commit, pending} !== exp_vec) begin
          failures++;
          $display("FAIL raster (%0d,%0d) got %b want %b", x, rows[r], {outg, err, commit, pending}, exp_vec);
        end
      end
    end
    pix(9, 10, 1);   tick(); checks++; if (outg !== 1'b0) begin failures++; $display("FAIL edge_9_10 got %b want 0", outg); end
    pix(110, 80, 1); tick(); checks++; if (outg !== 1'b1) begin failures++; $display("FAIL edge_110_80 got %b want 1", outg); end
    pix(111, 80, 1); tick(); checks++; if (outg !== 1'b0) begin failures++; $display("FAIL edge_111_80 got %b want 0", outg); end
    pix(50, 50, 0);  tick(); checks++; if (outg !== 1'b0) begin failures++; $display("FAIL en_low got %b want 0", outg); end
  endtask

  task automatic test_update();
    set_req(0, '{20, 40, 5, 6});
    ifc.req_valid = 2'b01; pix(50, 50, 1); tick();
    checks++; if (obs_ready !== 2'b01) begin failures++; $display("FAIL upd_ready got %b want 01", obs_ready); end
    checks++; if (pending !== 1'b1) begin failures++; $display("FAIL upd_pending got %b want 1", pending); end
    ifc.req_valid = 2'b00; pix(10, 10, 1); tick();
    checks++; if ({outg, commit, pending} !== 3'b101) begin failures++; $display("FAIL upd_old_window got %b want 101", {outg, commit, pending}); end
    set_req(1, '{0, 5, 0, 5});
    ifc.req_valid = 2'b10; pix(60, 60, 1); tick();
    checks++; if (obs_ready !== 2'b00) begin failures++; $display("FAIL hold_ready got %b want 00", obs_ready); end
    ifc.req_valid = 2'b00; pix(0, 0, 1); tick();
    checks++; if ({outg, commit, pending} !== 3'b010) begin failures++; $display("FAIL upd_commit got %b want 010", {outg, commit, pending}); end
    pix(20, 5, 1); tick();
    checks++; if ({outg, commit} !== 2'b10) begin failures++; $display("FAIL upd_new_pixel got %b want 10", {outg, commit}); end
    pix(10, 10, 1); tick();
    checks++; if (outg !== 1'b0) begin failures++; $display("FAIL upd_old_pixel got %b want 0", outg); end
  endtask

  task automatic test_round_robin();
    logic [1:0] want [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    int g;
    for (int f = 0; f < 4; f++) begin
      set_req(0, rand_box(1)); set_req(1, rand_box(1));
      ifc.req_valid = 2'b11; pix(30, 30, 1); tick();
      g = want[f][1] ? 1 : 0;
      checks++;
      if (obs_ready !== want[f] || obs_ready !== exp_ready) begin
        failures++; $display("FAIL rr_grant frame %0d got %b want %b", f, obs_ready, want[f]);
      end
      ifc.req_valid = 2'b00; pix(5, 5, 1); tick();
      pix(0, 0, 1); tick();
      checks++; if (commit !== 1'b1) begin failures++; $display("FAIL rr_commit frame %0d got %b want 1", f, commit); end
      pix(rq[g].x1, rq[g].y1, 1); tick();
      checks++; if (outg !== 1'b1) begin failures++; $display("FAIL rr_corner frame %0d got %b want 1", f, outg); end
    end
  endtask

  task automatic test_illegal();
    set_req(1, '{50, 30, 0, 0});
    ifc.req_valid = 2'b10; pix(70, 40, 1); tick();
    checks++; if (obs_ready !== 2'b10) begin failures++; $display("FAIL ill_ready got %b want 10", obs_ready); end
    checks++; if ({err, pending, commit} !== 3'b100) begin failures++; $display("FAIL ill_err got %b want 100", {err, pending, commit}); end
    ifc.req_valid = 2'b00; pix(70, 40, 1); tick();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL ill_err_pulse got %b want 0", err); end
    pix(0, 0, 1); tick();
    checks++; if ({commit, pending} !== 2'b00) begin failures++; $display("FAIL ill_no_commit got %b want 00", {commit, pending}); end
    pix(m_act.x2, m_act.y2, 1); tick();
    checks++; if (outg !== 1'b1) begin failures++; $display("FAIL ill_bounds_kept got %b want 1", outg); end
  endtask

  task automatic test_fs_accept();
    set_req(0, '{100, 200, 100, 200});
    ifc.req_valid = 2'b01; pix(0, 0, 1); tick();
    checks++; if ({obs_ready, pending, commit} !== 4'b0110) begin failures++; $display("FAIL fsacc_first got %b want 0110", {obs_ready, pending, commit}); end
    ifc.req_valid = 2'b00; pix(150, 150, 1); tick();
    checks++; if ({outg, commit, pending} !== 3'b001) begin failures++; $display("FAIL fsacc_wait got %b want 001", {outg, commit, pending}); end
    pix(0, 0, 1); tick();
    checks++; if ({commit, pending} !== 2'b10) begin failures++; $display("FAIL fsacc_commit got %b want 10", {commit, pending}); end
    pix(150, 150, 1); tick();
    checks++; if (outg !== 1'b1) begin failures++; $display("FAIL fsacc_window got %b want 1", outg); end
  endtask

  task automatic test_reset_hold();
    set_req(0, '{500, 600, 200, 300});
    ifc.req_valid = 2'b01; pix(40, 40, 1); tick();
    checks++; if (pending !== 1'b1) begin failures++; $display("FAIL rsthold_pending got %b want 1", pending); end
    test_reset();
    pix(0, 0, 1); tick();
    checks++; if ({commit, pending} !== 2'b00) begin failures++; $display("FAIL rsthold_commit got %b want 00", {commit, pending}); end
    pix(10, 10, 1); tick();
    checks++; if (outg !== 1'b1) begin failures++; $display("FAIL rsthold_default got %b want 1", outg); end
    pix(550, 250, 1); tick();
    checks++; if (outg !== 1'b0) begin failures++; $display("FAIL rsthold_discard got %b want 0", outg); end
  endtask

  task automatic test_random();
    int sel;
    for (int i = 0; i < 3000; i++) begin
      for (int n = 0; n < 2; n++)
        if (!ifc.req_valid[n] && $urandom_range(0, 3) == 0) set_req(n, rand_box($urandom_range(0, 3) != 0));
      ifc.req_valid = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      if (sel == 0)      pix(0, 0, 1);
      else if (sel < 5)  pix($urandom_range(0, 2047), $urandom_range(0, 1023), $urandom_range(0, 4) != 0);
      else if (sel < 7)  pix(m_act.x1 - 1 + $urandom_range(0, 1), m_act.y1 - 1 + $urandom_range(0, 1), 1);
      else               pix(m_act.x2 + $urandom_range(0, 1), m_act.y2 + $urandom_range(0, 1), 1);
      tick();
      checks++;
      if (obs_ready !== exp_ready) begin
        failures++; $display("FAIL rand_ready cycle %0d got %b want %b", i, obs_ready, exp_ready);
      end
      checks++;
      if ({outg, err, commit, pending} !== exp_vec) begin
        failures++; $display("FAIL rand_outputs cycle %0d got %b want %b", i, {outg, err, commit, pending}, exp_vec);
      end
    end
    ifc.req_valid = 2'b00;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; gr_x = '0; gr_y = '0;
    ifc.req_valid = 2'b00; ifc.req_x1 = '0; ifc.req_x2 = '0; ifc.req_y1 = '0; ifc.req_y2 = '0;
    rq[0] = '{0, 0, 0, 0}; rq[1] = '{0, 0, 0, 0};
    test_reset();
    test_default_window();
    test_update();
    test_reset();
    test_round_robin();
    test_illegal();
    test_fs_accept();
    test_reset_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/roi_window_ctrl.md
# roi_window_ctrl

Run-time controller for the green ROI rectangle overlay. It holds the active window bounds (x1, x2, y1, y2) and accepts new bounds from two requesters (0 = operator UI, 1 = auto-tracker) through valid/ready handshakes. Requests are arbitrated round-robin, checked for legality and committed only at a frame boundary, so a frame is never drawn with mixed bounds. It produces the registered overlay flag `outg` for the pixel pipeline.

## Interface
- `XW`, 11, x coordinate width
- `YW`, 10, y coordinate width
- `X1_RST`, 10, reset value of active x1
- `X2_RST`, 110, reset value of active x2
- `Y1_RST`, 10, reset value of active y1
- `Y2_RST`, 80, reset value of active y2

Ports:
- `clk`  in  1  pixel clock
- `reset`  in  1  asynchronous, active-high
- `en`  in  1  pixel valid for the current `gr_x`/`gr_y`
- `gr_x`  in  XW  raster x of the current pixel
- `gr_y`  in  YW  raster y of the current pixel
- `req_valid`  in  2  request valid, one bit per requester
- `req_ready`  out  2  request accepted this cycle, one bit per requester
- `req_x1`, `req_x2`  in  2×XW  packed, requester n at bits [n*XW +: XW]
- `req_y1`, `req_y2`  in  2×YW  packed, requester n at bits [n*YW +: YW]
- `pending`  out  1  an accepted update awaits commit
- `err`  out  1  one-cycle pulse: an illegal request was dropped
- `commit`  out  1  one-cycle pulse: new bounds applied
- `outg`  out  1  registered overlay flag

## Operation
- Frame start (`fs`) is `en && gr_x==0 && gr_y==0`.
- FSM, two states:
  - IDLE: `req_ready` is the one-hot grant when any `req_valid` is high, else 0.
  - HOLD: `req_ready` = 0.
- Arbitration in IDLE:
  - Only one requester valid: that requester is granted.
  - Both valid: grant goes to the requester not granted last. `last_gnt` resets to 1, so requester 0 wins the first tie.
- Handshake completes in the cycle where `req_valid[n] && req_ready[n]`. The bounds of that requester are sampled in that cycle.
- Legality: the request is legal only if `x1<=x2 && y1<=y2` (unsigned).
  - Legal request: load the shadow registers, update `last_gnt`, go to HOLD.
  - Illegal request: pulse `err` next cycle, stay in IDLE, update `last_gnt`.
- HOLD → IDLE on `fs`:
  - Shadow registers are copied to the active registers.
  - `commit` pulses in the following cycle.
- `fs` in the same cycle as an acceptance does not commit that request. Commit waits for the next `fs`.
- Requesters must hold `req_valid` and their data stable until they see ready. Dropping valid before ready is allowed and aborts the request silently.
- `pending` = (state == HOLD), registered.
- Overlay flag:
  - `outg` = `en && x1<=gr_x<=x2 && y1<=gr_y<=y2`, evaluated against the bounds in effect for this pixel.
  - The bounds in effect are the shadow values on the `fs` pixel of a commit, and the active values otherwise.
  - `en`=0 gives `outg`=0.

## Timing
- Reset values:
  - `outg`, `req_ready`, `pending`, `err`, `commit` = 0.
  - Active and shadow registers = *_RST.
  - State = IDLE.
- `outg` latency is one cycle: the inputs of cycle t are reflected in `outg` at t+1.
- `req_ready` is combinational from state, `req_valid` and `last_gnt`. It never asserts in HOLD.
- `err` and `commit` are registered single-cycle pulses at t+1.
- Requests arriving while in HOLD wait. The earliest grant is the cycle after commit.
- Reset mid-HOLD discards the pending update. The next frame draws the *_RST window.
- All compares are unsigned at full width. There is no wrap-around: `x2=2047` covers to the last column.

## Structure
- Shared package `roi_pkg`: XW/YW widths, *_RST defaults, FSM state encoding (IDLE=0, HOLD=1), and the bounds struct/bundle {x1,x2,y1,y2}.
- Sub-module `roi_rr_arb2`: 2-way round-robin arbiter with `last_gnt` register, taking valid[1:0] and gate, and producing one-hot grant.
- Top level: FSM, shadow/active registers, legality check, output compare register.

## Test plan
- Reset, then drive a raster with `en`=1:
  - `outg`=1 exactly for x∈[10,110], y∈[10,80].
  - (9,10)→0, (110,80)→1, (111,80)→0.
- Req0 {20,40,5,6} valid at mid-frame:
  - `req_ready[0]` pulses once and `pending`=1.
  - Window unchanged until `fs`; `commit` pulses on the cycle after `fs`.
  - Pixel (20,5) of the new frame → `outg`=1; old window pixel (10,10) → 0.
- Req0 and req1 valid simultaneously, repeated over 4 frames: grants alternate 0,1,0,1.
- Req1 {50,30,0,0} (x1>x2): `err` pulses, state stays IDLE, active bounds unchanged, no `commit`.
- Acceptance on the same cycle as `fs`: no commit that frame; commit occurs on the next `fs`.
- Assert `reset` while `pending`=1: all outputs 0, `pending`=0, next frame draws the {10,110,10,80} window.
